// File: rtl/uart_fifo_link.sv
`default_nettype none
// uart_fifo_link - full-duplex UART, FWFT FIFOs on TX and RX, echo mode, sticky errors.
// Optional even parity: define UART_FIFO_LINK_PARITY_EN. Revision 1.0

module uart_fifo_link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Callers qualify push/pop, so a push while full only arrives together with a pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end

  assign rdata = mem[rd_ptr];
endmodule

module uart_fifo_link #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115_200,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ena,
  input  logic                          rx_signal,
  output logic                          tx_signal,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  input  logic                          echo_en,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          clear_err
);
  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(STOP_BITS * BIT_CLKS + 1);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * BIT_CLKS - 1);
  localparam logic [IW-1:0] BITS_LAST = IW'(DATA_WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

`ifdef UART_FIFO_LINK_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t                tx_state, rx_state;
  logic [CW-1:0]         tx_cnt, rx_cnt;
  logic [IW-1:0]         tx_idx, rx_idx;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, txf_head, txf_wdata;
  logic                  sync1, sync2, rx_perr;
  logic                  tx_full, tx_empty, rx_full;
  logic                  txf_push, txf_pop, rxf_push, rxf_pop;
  logic                  stop_sample, rx_done, ovf_set, fe_set;

  always_ff @(posedge clk) begin
    if (!reset_n) {sync2, sync1} <= 2'b11;
    else          {sync2, sync1} <= {sync1, rx_signal};
  end

  assign tx_full  = (tx_level == FULL_LVL);
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == FULL_LVL);
  assign rx_valid = (rx_level != '0);
  assign tx_ready = !tx_full && !echo_en;

  assign stop_sample = ena && (rx_state == S_STOP) && (rx_cnt == BIT_LAST);
  assign rx_done     = stop_sample && sync2 && !rx_perr;
  assign fe_set      = stop_sample && (!sync2 || rx_perr);
  assign txf_pop     = ena && !tx_empty &&
                       ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_cnt == STOP_LAST)));
  assign rxf_pop     = ena && rx_valid && rx_ready;
  // echo_en selects the destination of each completed character at its stop sample.
  assign txf_push    = echo_en ? (rx_done && (!tx_full || txf_pop))
                               : (ena && tx_valid && tx_ready);
  assign txf_wdata   = echo_en ? rx_shift : tx_data;
  assign rxf_push    = rx_done && !echo_en && (!rx_full || rxf_pop);
  assign ovf_set     = rx_done && (echo_en ? (tx_full && !txf_pop) : (rx_full && !rxf_pop));

  uart_fifo_link_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(txf_push), .pop(txf_pop),
    .wdata(txf_wdata), .rdata(txf_head), .level(tx_level)
  );

  uart_fifo_link_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rxf_push), .pop(rxf_pop),
    .wdata(rx_shift), .rdata(rx_data), .level(rx_level)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (ena) begin
      if (ovf_set)        overflow  <= 1'b1;
      else if (clear_err) overflow  <= 1'b0;
      if (fe_set)         frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
    end
  end

`ifdef UART_FIFO_LINK_PARITY_EN
  logic tx_par;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_signal <= 1'b1;
`ifdef UART_FIFO_LINK_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else if (ena) begin
      case (tx_state)
        S_IDLE: if (txf_pop) begin
          tx_state  <= S_START;
          tx_shift  <= txf_head;
          tx_cnt    <= '0;
          tx_signal <= 1'b0;
`ifdef UART_FIFO_LINK_PARITY_EN
          tx_par    <= ^txf_head;
`endif
        end
        S_START: if (tx_cnt == BIT_LAST) begin
          tx_state  <= S_DATA;
          tx_cnt    <= '0;
          tx_idx    <= '0;
          tx_signal <= tx_shift[0];
        end else tx_cnt <= tx_cnt + CW'(1);
        S_DATA: if (tx_cnt == BIT_LAST) begin
          tx_cnt <= '0;
          if (tx_idx == BITS_LAST) begin
`ifdef UART_FIFO_LINK_PARITY_EN
            tx_state  <= S_PARITY;
            tx_signal <= tx_par;
`else
            tx_state  <= S_STOP;
            tx_signal <= 1'b1;
`endif
          end else begin
            tx_idx    <= tx_idx + IW'(1);
            tx_shift  <= tx_shift >> 1;
            tx_signal <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + CW'(1);
`ifdef UART_FIFO_LINK_PARITY_EN
        S_PARITY: if (tx_cnt == BIT_LAST) begin
          tx_state  <= S_STOP;
          tx_cnt    <= '0;
          tx_signal <= 1'b1;
        end else tx_cnt <= tx_cnt + CW'(1);
`endif
        // A queued character starts straight out of STOP so frames run back to back.
        S_STOP: if (tx_cnt == STOP_LAST) begin
          tx_cnt <= '0;
          if (txf_pop) begin
            tx_state  <= S_START;
            tx_shift  <= txf_head;
            tx_signal <= 1'b0;
`ifdef UART_FIFO_LINK_PARITY_EN
            tx_par    <= ^txf_head;
`endif
          end else tx_state <= S_IDLE;
        end else tx_cnt <= tx_cnt + CW'(1);
        default: begin
          tx_state  <= S_IDLE;
          tx_signal <= 1'b1;
        end
      endcase
    end
  end

`ifndef UART_FIFO_LINK_PARITY_EN
  assign rx_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
`ifdef UART_FIFO_LINK_PARITY_EN
      rx_perr  <= 1'b0;
`endif
    end else if (ena) begin
      case (rx_state)
        S_IDLE: if (!sync2) begin
          rx_state <= S_START;
          rx_cnt   <= '0;
        end
        S_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_idx   <= '0;
          rx_state <= sync2 ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {sync2, rx_shift[DATA_WIDTH-1:1]};
          if (rx_idx == BITS_LAST) begin
`ifdef UART_FIFO_LINK_PARITY_EN
            rx_state <= S_PARITY;
`else
            rx_state <= S_STOP;
`endif
          end else rx_idx <= rx_idx + IW'(1);
        end else rx_cnt <= rx_cnt + CW'(1);
`ifdef UART_FIFO_LINK_PARITY_EN
        S_PARITY: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_perr  <= sync2 ^ (^rx_shift);
          rx_state <= S_STOP;
        end else rx_cnt <= rx_cnt + CW'(1);
`endif
        S_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_state <= sync2 ? S_IDLE : S_BREAK;
        end else rx_cnt <= rx_cnt + CW'(1);
        S_BREAK: if (sync2) rx_state <= S_IDLE;
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_link.sv
`default_nettype none
// tb_uart_fifo_link - table vectors, corner sequences and randomized traffic against a queue model.
// Revision 1.0

module tb_uart_fifo_link;
  localparam int DW = 8;
  localparam int BC = 10;
  localparam int LW = 3;

  logic          clk = 1'b0, reset_n = 1'b0, ena = 1'b1, rx_signal = 1'b1;
  logic          tx_valid = 1'b0, rx_ready = 1'b0, echo_en = 1'b0, clear_err = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_signal, tx_ready, rx_valid, overflow, frame_err;
  logic [DW-1:0] rx_data;
  logic [LW-1:0] tx_level, rx_level;

  int compared = 0, mismatched = 0, cyc = 0;

  uart_fifo_link #(.DATA_WIDTH(DW), .BAUD_RATE(100_000), .CLK_FREQ(1_000_000),
                   .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .rx_signal(rx_signal), .tx_signal(tx_signal),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .echo_en(echo_en), .tx_level(tx_level),
    .rx_level(rx_level), .overflow(overflow), .frame_err(frame_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop);
    rx_signal = 1'b0; tick(BC);
    for (int i = 0; i < DW; i++) begin rx_signal = d[i]; tick(BC); end
    rx_signal = stop; tick(BC);
    rx_signal = 1'b1;
  endtask

  task automatic tx_push(input logic [DW-1:0] d);
    int n = 0;
    while (!tx_ready && n < 1000) begin tick(1); n++; end
    tx_data = d; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
  endtask

  task automatic capture(output logic [DW-1:0] d, output int sc);
    int n = 0;
    d = '0; sc = -1;
    while (tx_signal !== 1'b0 && n < 400) begin tick(1); n++; end
    if (tx_signal !== 1'b0) begin
      compared++; mismatched++;
      $display("FAIL tx_start_timeout: actual no start bit, required start within 400 cycles");
      return;
    end
    sc = cyc;
    tick(BC / 2);
    check("tx_start_bit", tx_signal, 0);
    for (int i = 0; i < DW; i++) begin tick(BC); d[i] = tx_signal; end
    tick(BC);
    check("tx_stop_bit", tx_signal, 1);
  endtask

  task automatic pop_one;
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
  endtask

  task automatic clear_flags;
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic          exp_valid;
    logic          exp_fe;
  } rx_vec_t;

  rx_vec_t        vecs[5];
  logic [DW-1:0]  q[$];
  logic [DW-1:0]  got;
  int             sc, prev_sc, n_chars;
  logic           exp_ovf;
  logic [DW-1:0]  frame_bits;

  initial begin
    vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 1'b0, 1'b0, 1'b1};

    // Reset state
    tick(3);
    check("rst_tx_signal", tx_signal, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_tx_level", tx_level, 0);
    check("rst_rx_level", rx_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    reset_n = 1'b1; tick(2);

    // TX 0xA5: exact line waveform cycle by cycle
    frame_bits = 8'hA5;
    tx_data = 8'hA5; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    check("tx1_level_after_push", tx_level, 1);
    check("tx1_line_still_idle", tx_signal, 1);
    tick(1);
    check("tx1_level_at_start", tx_level, 0);
    for (int k = 0; k < 110; k++) begin
      check($sformatf("tx1_line_cycle%0d", k), tx_signal,
            (k < BC) ? 0 : (k < 9 * BC) ? 32'(frame_bits[(k - BC) / BC]) : 1);
      tick(1);
    end

    // Table-driven RX vectors (normal and stop-bit error)
    foreach (vecs[v]) begin
      clear_flags();
      send_frame(vecs[v].data, vecs[v].stop);
      check($sformatf("vec%0d_rx_valid", v), rx_valid, vecs[v].exp_valid);
      check($sformatf("vec%0d_rx_level", v), rx_level, vecs[v].exp_valid ? 1 : 0);
      check($sformatf("vec%0d_frame_err", v), frame_err, vecs[v].exp_fe);
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].data);
        pop_one();
        check($sformatf("vec%0d_popped", v), rx_valid, 0);
      end
      tick(5);
    end
    clear_flags();
    check("fe_cleared", frame_err, 0);

    // Glitch: 3-cycle low pulse is ignored, then a real frame still decodes
    rx_signal = 1'b0; tick(3); rx_signal = 1'b1; tick(20);
    check("glitch_no_fe", frame_err, 0);
    check("glitch_no_push", rx_valid, 0);
    send_frame(8'h96, 1'b1);
    check("post_glitch_data", rx_data, 8'h96);
    pop_one(); tick(5);

    // Overflow: five characters with no consumer
    for (int i = 1; i <= 5; i++) send_frame(DW'(i), 1'b1);
    tick(3);
    check("ovf_level", rx_level, 4);
    check("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf_pop%0d", i), rx_data, i);
      pop_one();
    end
    check("ovf_drained", rx_valid, 0);
    check("ovf_sticky", overflow, 1);
    clear_flags();
    check("ovf_cleared", overflow, 0);

    // Echo: received character goes out on TX, tx_valid ignored
    echo_en = 1'b1; tx_valid = 1'b1; tx_data = 8'h99; tick(1);
    check("echo_tx_ready", tx_ready, 0);
    fork
      send_frame(8'h7E, 1'b1);
      capture(got, sc);
    join
    check("echo_data", got, 8'h7E);
    check("echo_rx_level", rx_level, 0);
    tick(20);
    check("echo_tx_level", tx_level, 0);
    tx_valid = 1'b0; echo_en = 1'b0; tick(2);

    // ena=0 freezes the TX FIFO
    ena = 1'b0; tx_data = 8'h33; tx_valid = 1'b1; tick(3); tx_valid = 1'b0;
    check("ena_hold_level", tx_level, 0);
    check("ena_hold_line", tx_signal, 1);
    ena = 1'b1; tick(2);

    // Reset during bit 3 of 0xFF with a second character queued
    tx_push(8'hFF); tx_push(8'h11);
    tick(44);
    reset_n = 1'b0; tick(1);
    check("rst_mid_tx_line", tx_signal, 1);
    check("rst_mid_tx_level", tx_level, 0);
    reset_n = 1'b1; tick(2);
    fork
      tx_push(8'h5A);
      capture(got, sc);
    join
    check("rst_mid_tx_resume", got, 8'h5A);
    tick(20);

    // Randomized RX bursts against a queue model of the RX FIFO
    for (int r = 0; r < 3; r++) begin
      n_chars = $urandom_range(1, 6);
      q.delete(); exp_ovf = 1'b0;
      for (int i = 0; i < n_chars; i++) begin
        got = DW'($urandom);
        if (q.size() < 4) q.push_back(got); else exp_ovf = 1'b1;
        send_frame(got, 1'b1);
      end
      tick(3);
      check($sformatf("rnd_rx%0d_level", r), rx_level, q.size());
      check($sformatf("rnd_rx%0d_ovf", r), overflow, exp_ovf);
      while (q.size() > 0) begin
        check($sformatf("rnd_rx%0d_data", r), rx_data, q.pop_front());
        pop_one();
      end
      check($sformatf("rnd_rx%0d_empty", r), rx_valid, 0);
      clear_flags();
    end

    // Randomized TX bursts: order preserved, no idle gap between frames
    for (int r = 0; r < 3; r++) begin
      n_chars = $urandom_range(1, 4);
      q.delete();
      for (int i = 0; i < n_chars; i++) q.push_back(DW'($urandom));
      fork
        begin
          for (int i = 0; i < n_chars; i++) tx_push(q[i]);
        end
        begin
          prev_sc = -1;
          for (int i = 0; i < n_chars; i++) begin
            capture(got, sc);
            check($sformatf("rnd_tx%0d_char%0d", r, i), got, q[i]);
            if (i > 0) check($sformatf("rnd_tx%0d_gap%0d", r, i), sc - prev_sc, (DW + 2) * BC);
            prev_sc = sc;
          end
        end
      join
      tick(20);
      check($sformatf("rnd_tx%0d_idle", r), tx_signal, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
